// File: rtl/uart_alu_runner.sv
// uart_alu_runner
//   Receives ALU command packets over a UART (8N1, LSB first), folds the
//   32-bit operands into an accumulator (0x10 = sum, 0x11 = product, both
//   modulo 2^32) and returns the 32-bit result as 4 bytes, little-endian.
//
//   Packet: opcode, reserved, N[7:0], N[15:8], then N operands of 4 bytes each
//   (little-endian).
//
// Parameters
//   CLK_FREQ_HZ - system clock frequency
//   BAUD_RATE   - serial bit rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
//
// Ports
//   clk_i   - sole clock, rising edge
//   reset_i - synchronous, active-high reset
//   rx_i    - asynchronous UART receive line, idle high
//   tx_o    - UART transmit line, idle high
//   busy_o  - high from the first packet byte until the response's last
//             stop bit has ended
//
// Build option
//   UART_ALU_ERR_RESP_EN - when defined, an unknown opcode answers 0xFFFFFFFF
//   once its payload has been consumed; when undefined it stays silent.
//
// Debug visibility: the packet FSM state is held in state_q (type state_t).
module uart_alu_runner #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o
);

  localparam int          CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);
  localparam logic [7:0]  OP_ADD       = 8'h10;
  localparam logic [7:0]  OP_MUL       = 8'h11;

`ifdef UART_ALU_ERR_RESP_EN
  localparam bit ERR_RESP = 1'b1;
`else
  localparam bit ERR_RESP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CALC, S_RESP} state_t;

  // ---------------------------------------------------------------- receiver
  // rx_valid is a one-cycle strobe carrying rx_data. There is no ready:
  // the consumer takes the byte in that cycle or it is gone. The packet FSM
  // simply ignores it while a response is being sent, which is how bytes
  // arriving during a response get discarded.
  logic        rx_meta, rx_sync;
  logic        rx_active;
  logic [3:0]  rx_bit;      // 0 = start, 1..8 = data, 9 = stop
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic        rx_valid;
  logic [7:0]  rx_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_active <= 1'b0;
      rx_bit    <= '0;
      rx_cnt    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
    end else begin
      rx_meta  <= rx_i;
      rx_sync  <= rx_meta;
      rx_valid <= 1'b0;
      if (!rx_active) begin
        if (!rx_sync) begin
          rx_active <= 1'b1;
          rx_bit    <= '0;
          rx_cnt    <= '0;
        end
      // The start bit is sampled half a bit after the falling edge; every
      // later sample is one full bit after the previous one (mid-bit).
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF_LAST : BIT_LAST)) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_sync) rx_active <= 1'b0;   // glitch, not a real start bit
        end else if (rx_bit == 4'd9) begin
          rx_active <= 1'b0;
          if (rx_sync) begin                // framing error drops the byte
            rx_valid <= 1'b1;
            rx_data  <= rx_shift;
          end
        end else begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------- packet FSM
  state_t      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [1:0]  hdr_idx_q;
  logic [7:0]  n_lo_q;
  logic [15:0] n_rem_q;
  logic [1:0]  op_idx_q;
  logic [31:0] operand_q;
  logic [31:0] acc_q;
  logic [31:0] resp_q;
  logic [1:0]  tx_byte_q;
  logic [3:0]  tx_bit_q;
  logic [15:0] tx_cnt_q;

  logic        known;
  logic        answer;
  logic [31:0] acc_fold;
  logic [31:0] resp_value;
  logic [15:0] n_hdr;
  logic        tx_bit_end;
  logic        tx_last;
  logic [7:0]  tx_cur;

  always_comb begin
    known      = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    answer     = known || ERR_RESP;
    acc_fold   = (opcode_q == OP_ADD) ? acc_q + operand_q :
                 (opcode_q == OP_MUL) ? acc_q * operand_q : acc_q;
    // Entering RESP from CALC happens in the same cycle as the last fold,
    // so the folded value is captured directly.
    resp_value = !known ? 32'hFFFF_FFFF :
                 (state_q == S_CALC) ? acc_fold : acc_q;
    n_hdr      = {rx_data, n_lo_q};
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    tx_last    = tx_bit_end && (tx_bit_q == 4'd9) && (tx_byte_q == 2'd3);
    tx_cur     = resp_q[{tx_byte_q, 3'b000} +: 8];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rx_valid) state_d = S_HDR;
      S_HDR: begin
        if (rx_valid && hdr_idx_q == 2'd3) begin
          if (n_hdr != 16'd0) state_d = S_DATA;
          else                state_d = answer ? S_RESP : S_IDLE;
        end
      end
      S_DATA: if (rx_valid && op_idx_q == 2'd3) state_d = S_CALC;
      S_CALC: begin
        if (n_rem_q != 16'd1) state_d = S_DATA;
        else                  state_d = answer ? S_RESP : S_IDLE;
      end
      S_RESP: if (tx_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      hdr_idx_q <= '0;
      n_lo_q    <= '0;
      n_rem_q   <= '0;
      op_idx_q  <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      resp_q    <= '0;
      tx_byte_q <= '0;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            opcode_q  <= rx_data;
            acc_q     <= (rx_data == OP_MUL) ? 32'd1 : 32'd0;
            hdr_idx_q <= 2'd1;
            op_idx_q  <= 2'd0;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            hdr_idx_q <= hdr_idx_q + 2'd1;
            if (hdr_idx_q == 2'd2) n_lo_q  <= rx_data;
            if (hdr_idx_q == 2'd3) n_rem_q <= n_hdr;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            operand_q <= {rx_data, operand_q[31:8]};
            op_idx_q  <= op_idx_q + 2'd1;
          end
        end
        S_CALC: begin
          acc_q   <= acc_fold;
          n_rem_q <= n_rem_q - 16'd1;
        end
        S_RESP: begin
          if (tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              tx_bit_q  <= '0;
              tx_byte_q <= tx_byte_q + 2'd1;
            end else begin
              tx_bit_q <= tx_bit_q + 4'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
      if (state_q != S_RESP && state_d == S_RESP) begin
        resp_q    <= resp_value;
        tx_byte_q <= '0;
        tx_bit_q  <= '0;
        tx_cnt_q  <= '0;
      end
    end
  end

  // Frame bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    tx_o = 1'b1;
    if (state_q == S_RESP) begin
      if (tx_bit_q == 4'd0)      tx_o = 1'b0;
      else if (tx_bit_q <= 4'd8) tx_o = tx_cur[3'(tx_bit_q - 4'd1)];
    end
    busy_o = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_uart_alu_runner.sv
module tb_uart_alu_runner;
  localparam int CPB = 4;   // 1 MHz / 250 kbaud

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx;
  logic busy;

  int total = 0;
  int bad = 0;
  logic [31:0] ops_buf[16];
  logic [31:0] exp_q[$];

  // ---------------------------------------------------- clock / reset block
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_alu_runner #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(250_000)) dut (
    .clk_i(clk), .reset_i(reset), .rx_i(rx), .tx_o(tx), .busy_o(busy)
  );

  // --------------------------------------------------------- driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] op, input int n);
    logic [15:0] nn;
    logic [31:0] w;
    nn = 16'(n);
    send_byte(op);
    send_byte(8'h00);
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    for (int k = 0; k < n; k++) begin
      w = ops_buf[k];
      for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
    end
  endtask

  task automatic recv_byte(input int budget, output logic [7:0] b, output bit ok);
    int waited;
    waited = 0;
    ok = 1'b1;
    b = '0;
    while (tx !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic recv_word(output logic [31:0] w, output bit ok);
    logic [7:0] b;
    bit k;
    w = '0;
    recv_byte(20000, b, k);
    ok = k;
    w[7:0] = b;
    for (int i = 1; i < 4; i++) begin
      if (ok) begin
        recv_byte(3 * CPB, b, k);
        ok = ok & k;
        w[8*i +: 8] = b;
      end
    end
  endtask

  task automatic run_txn(input logic [7:0] op, input int n,
                         output logic [31:0] got, output bit ok);
    logic [31:0] g;
    bit o;
    fork
      send_packet(op, n);
      recv_word(g, o);
    join
    got = g;
    ok = o;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got=%b want=1", tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL post_reset_tx: got=%b want=1", tx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got=%b want=0", busy); end
  endtask

  task automatic test_busy;
    logic [31:0] got;
    bit ok;
    logic busy_mid;
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    fork
      send_packet(8'h10, 2);
      recv_word(got, ok);
      begin repeat (15 * CPB) @(negedge clk); busy_mid = busy; end
    join
    total++;
    if (busy_mid !== 1'b1) begin bad++; $display("FAIL busy_mid_packet: got=%b want=1", busy_mid); end
    total++;
    if (!ok || got !== 32'h3) begin bad++; $display("FAIL busy_add12: got=%h ok=%0d want=00000003", got, ok); end
    repeat (CPB + 2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_resp: got=%b want=0", busy); end
  endtask

  task automatic test_add;
    logic [31:0] got;
    bit ok;
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h3) begin bad++; $display("FAIL add_1_2: got=%h ok=%0d want=00000003", got, ok); end
    ops_buf[0] = 32'd3; ops_buf[1] = 32'd4;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h7) begin bad++; $display("FAIL add_3_4: got=%h ok=%0d want=00000007", got, ok); end
  endtask

  task automatic test_mul;
    logic [31:0] got;
    bit ok;
    ops_buf[0] = 32'd5; ops_buf[1] = 32'd6;
    run_txn(8'h11, 2, got, ok);
    total++;
    if (!ok || got !== 32'h1E) begin bad++; $display("FAIL mul_5_6: got=%h ok=%0d want=0000001e", got, ok); end
    for (int i = 0; i < 5; i++) ops_buf[i] = 32'(i + 1);
    run_txn(8'h11, 5, got, ok);
    total++;
    if (!ok || got !== 32'h78) begin bad++; $display("FAIL mul_1to5: got=%h ok=%0d want=00000078", got, ok); end
  endtask

  task automatic test_overflow;
    logic [31:0] got;
    bit ok;
    ops_buf[0] = 32'hFFFF_FFFF; ops_buf[1] = 32'h0000_0002;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h1) begin bad++; $display("FAIL add_wrap: got=%h ok=%0d want=00000001", got, ok); end
    ops_buf[0] = 32'h0001_0000; ops_buf[1] = 32'h0001_0000;
    run_txn(8'h11, 2, got, ok);
    total++;
    if (!ok || got !== 32'h0) begin bad++; $display("FAIL mul_wrap: got=%h ok=%0d want=00000000", got, ok); end
  endtask

  task automatic test_n_edges;
    logic [31:0] got;
    bit ok;
    run_txn(8'h10, 0, got, ok);
    total++;
    if (!ok || got !== 32'h0) begin bad++; $display("FAIL add_n0: got=%h ok=%0d want=00000000", got, ok); end
    run_txn(8'h11, 0, got, ok);
    total++;
    if (!ok || got !== 32'h1) begin bad++; $display("FAIL mul_n0: got=%h ok=%0d want=00000001", got, ok); end
    ops_buf[0] = 32'hDEAD_BEEF;
    run_txn(8'h10, 1, got, ok);
    total++;
    if (!ok || got !== 32'hDEAD_BEEF) begin bad++; $display("FAIL add_n1: got=%h ok=%0d want=deadbeef", got, ok); end
    ops_buf[0] = 32'h1234_5678;
    run_txn(8'h11, 1, got, ok);
    total++;
    if (!ok || got !== 32'h1234_5678) begin bad++; $display("FAIL mul_n1: got=%h ok=%0d want=12345678", got, ok); end
  endtask

  task automatic test_reset_mid_packet;
    logic [31:0] got;
    bit ok;
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_packet_outputs: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h3) begin bad++; $display("FAIL after_reset_add: got=%h ok=%0d want=00000003", got, ok); end
  endtask

  task automatic test_reset_mid_response;
    logic [31:0] got;
    bit ok;
    bit seen_low;
    bit tx_active;
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    seen_low = 1'b0;
    fork
      send_packet(8'h10, 2);
      begin
        for (int i = 0; i < 5000 && !seen_low; i++) begin
          @(negedge clk);
          if (tx === 1'b0) seen_low = 1'b1;
        end
      end
    join
    total++;
    if (!seen_low) begin bad++; $display("FAIL resp_start: got=no start bit want=start bit"); end
    repeat (12 * CPB) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_mid_resp: got=%b want=1", busy); end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_resp_outputs: tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    tx_active = 1'b0;
    repeat (40 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_active = 1'b1;
    end
    total++;
    if (tx_active) begin bad++; $display("FAIL resp_after_reset: got=tx activity want=idle"); end
    ops_buf[0] = 32'd3; ops_buf[1] = 32'd4;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h7) begin bad++; $display("FAIL add_after_resp_reset: got=%h ok=%0d want=00000007", got, ok); end
  endtask

  task automatic test_unknown_opcode;
    logic [31:0] got;
    bit ok;
    ops_buf[0] = 32'hA5A5_5A5A;
`ifdef UART_ALU_ERR_RESP_EN
    run_txn(8'h20, 1, got, ok);
    total++;
    if (!ok || got !== 32'hFFFF_FFFF) begin bad++; $display("FAIL unknown_err_resp: got=%h ok=%0d want=ffffffff", got, ok); end
`else
    begin
      bit done;
      bit tx_active;
      done = 1'b0;
      tx_active = 1'b0;
      fork
        begin send_packet(8'h20, 1); repeat (60 * CPB) @(negedge clk); done = 1'b1; end
        begin
          while (!done) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_active = 1'b1;
          end
        end
      join
      total++;
      if (tx_active) begin bad++; $display("FAIL unknown_silent: got=tx activity want=idle"); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL unknown_busy: got=%b want=0", busy); end
    end
`endif
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h3) begin bad++; $display("FAIL add_after_unknown: got=%h ok=%0d want=00000003", got, ok); end
  endtask

  task automatic test_discard_during_resp;
    logic [31:0] got;
    bit ok;
    ops_buf[0] = 32'd1; ops_buf[1] = 32'd2;
    fork
      run_txn(8'h10, 2, got, ok);
      begin
        int waited;
        waited = 0;
        while (tx !== 1'b0 && waited < 5000) begin @(negedge clk); waited++; end
        repeat (10) @(negedge clk);
        send_byte(8'h10);
      end
    join
    total++;
    if (!ok || got !== 32'h3) begin bad++; $display("FAIL discard_add12: got=%h ok=%0d want=00000003", got, ok); end
    ops_buf[0] = 32'd3; ops_buf[1] = 32'd4;
    run_txn(8'h10, 2, got, ok);
    total++;
    if (!ok || got !== 32'h7) begin bad++; $display("FAIL discard_next_add: got=%h ok=%0d want=00000007", got, ok); end
  endtask

  task automatic test_fuzz;
    logic [31:0] got;
    logic [31:0] expv;
    logic [31:0] acc;
    logic [7:0]  op;
    bit ok;
    int n;
    for (int p = 0; p < 20; p++) begin
      op  = (p < 10) ? 8'h10 : 8'h11;
      n   = $urandom_range(2, 15);
      acc = (op == 8'h10) ? 32'd0 : 32'd1;
      for (int k = 0; k < n; k++) begin
        ops_buf[k] = $urandom;
        if (op == 8'h10) acc = acc + ops_buf[k];
        else             acc = acc * ops_buf[k];
      end
      exp_q.push_back(acc);
      run_txn(op, n, got, ok);
      expv = exp_q.pop_front();
      total++;
      if (!ok || got !== expv) begin
        bad++; $display("FAIL fuzz_%0d op=%h n=%0d: got=%h ok=%0d want=%h", p, op, n, got, ok, expv);
      end
    end
  endtask

  // ----------------------------------------------------------- sequencer
  initial begin
    test_reset();
    test_busy();
    test_add();
    test_mul();
    test_overflow();
    test_n_edges();
    test_reset_mid_packet();
    test_reset_mid_response();
    test_unknown_opcode();
    test_discard_during_resp();
    test_fuzz();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
